zbc_clmul_seq: RTL and testbench

//  Iterative carry-less multiplier for the RV64 Zbc ops clmul, clmulh and clmulr.

---
 rtl/zbc_clmul_seq.sv | 149 ++++++++++++++
 tb/tb_zbc_clmul_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zbc_clmul_seq.sv
// Iterative carry-less multiplier for RV64 Zbc clmul / clmulh / clmulr.
// Consumes BITS_PER_CYCLE multiplier bits per BUSY cycle; the result is a
// combinational slice of the 2*WIDTH product selected by the latched op.

// One partial-product lane: the running shifted multiplicand, shifted a
// further SHIFT places and gated by the multiplier bit that lane owns.
module zbc_clmul_lane #(
  parameter int WIDTH = 64,
  parameter int SHIFT = 0
) (
  input  logic [2*WIDTH-1:0] i_a_sh,
  input  logic               i_bit,
  output logic [2*WIDTH-1:0] o_pp
);
  assign o_pp = i_bit ? (i_a_sh << SHIFT) : '0;
endmodule

module zbc_clmul_seq #(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [1:0]       i_in_op,
  input  logic [WIDTH-1:0] i_in_a,
  input  logic [WIDTH-1:0] i_in_b,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_result
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    OP_CLMUL  = 2'b00,
    OP_CLMULH = 2'b01,
    OP_CLMULR = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  typedef struct packed {
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  state_e                                r_state, w_state_nxt;
  op_e                                   r_op;
  logic [PW-1:0]                         r_p;
  logic [PW-1:0]                         r_a_sh;   // a << (cnt*BPC)
  logic [WIDTH-1:0]                      r_b_sh;   // b >> (cnt*BPC)
  logic [CW-1:0]                         r_cnt;
  logic [BITS_PER_CYCLE-1:0][PW-1:0]     w_pp;
  logic [PW-1:0]                         w_pp_sum;
  logic                                  w_accept;
  logic                                  w_last;
  req_t                                  w_req;

  assign w_req    = '{op: op_e'(i_in_op), a: i_in_a, b: i_in_b};
  assign w_accept = (r_state == S_IDLE) && i_in_valid && !i_flush;
  assign w_last   = (r_cnt == CW'(N - 1));

  // Partial-product lanes, one per multiplier bit consumed this cycle
  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_lane
    zbc_clmul_lane #(
      .WIDTH (WIDTH),
      .SHIFT (k)
    ) u_lane (
      .i_a_sh (r_a_sh),
      .i_bit  (r_b_sh[k]),
      .o_pp   (w_pp[k])
    );
  end

  // GF(2) sum of this cycle's partial products
  always_comb begin
    w_pp_sum = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) w_pp_sum = w_pp_sum ^ w_pp[k];
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_in_valid) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last)     w_state_nxt = S_DONE;
      S_DONE:  if (i_out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_flush) w_state_nxt = S_IDLE;
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Operand capture and per-cycle product accumulation
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op   <= OP_CLMUL;
      r_p    <= '0;
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_p    <= '0;
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_op   <= w_req.op;
      r_p    <= '0;
      r_a_sh <= {{WIDTH{1'b0}}, w_req.a};
      r_b_sh <= w_req.b;
      r_cnt  <= '0;
    end else if (r_state == S_BUSY) begin
      r_p    <= r_p ^ w_pp_sum;
      r_a_sh <= r_a_sh << BITS_PER_CYCLE;
      r_b_sh <= r_b_sh >> BITS_PER_CYCLE;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  // Result slice; P[PW-1] is always zero so clmulh's top bit is too
  always_comb begin
    case (r_op)
      OP_CLMULH: o_out_result = r_p[PW-1:WIDTH];
      OP_CLMULR: o_out_result = r_p[PW-2:WIDTH-1];
      default:   o_out_result = r_p[WIDTH-1:0];
    endcase
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_DONE);

endmodule

// File: tb/tb_zbc_clmul_seq.sv
// Self-checking bench for zbc_clmul_seq: directed corner cases, handshake,
// flush and async reset scenarios, plus randomized ops against a GF(2) model.
module tb_zbc_clmul_seq;

  localparam int W   = 64;
  localparam int LAT = 16;

  logic         clk = 0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_a, in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  zbc_clmul_seq #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_op      (in_op),
    .i_in_a       (in_a),
    .i_in_b       (in_b),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_result (out_result)
  );

  // Reference: textbook carry-less product, bit i of b selects a << i
  function automatic logic [W-1:0] ref_result(input logic [1:0] op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = '0;
    for (int i = 0; i < W; i++)
      if (b[i]) p = p ^ ({{W{1'b0}}, a} << i);
    case (op)
      2'b01:   return p[2*W-1:W];
      2'b10:   return p[2*W-2:W-1];
      default: return p[W-1:0];
    endcase
  endfunction

  // Present an op and step through the accept edge; afterwards the bench is
  // one step past that edge and the operand buses are scrambled.
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL start_ready: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1; in_op = op; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 0;
    in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
    in_op = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done(output int lat, output bit rdy_hi);
    lat = 0; rdy_hi = 0;
    while (!out_valid && lat < 64) begin
      if (in_ready) rdy_hi = 1;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic pop();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== '0) begin
      errors++;
      $display("FAIL reset: rdy=%0b vld=%0b res=%h required 1 0 0",
               in_ready, out_valid, out_result);
    end
  endtask

  task automatic test_basic();
    int lat; bit rdy_hi;
    start_op(2'b00, 64'd3, 64'd3);
    wait_done(lat, rdy_hi);
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL basic_latency: got %0d required %0d", lat, LAT); end
    checks++;
    if (rdy_hi) begin errors++; $display("FAIL basic_ready_low: in_ready seen 1 required 0"); end
    checks++;
    if (out_result !== 64'h5) begin errors++; $display("FAIL basic_result: got %h required %h", out_result, 64'h5); end
    pop();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_after_pop: vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_corners();
    logic [W-1:0] av [6];
    logic [1:0]   ov [6];
    logic [W-1:0] ev [6];
    int lat; bit rdy_hi;
    av = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
    ov = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
    ev = '{64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA,
           64'h0, 64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000};
    for (int i = 0; i < 6; i++) begin
      start_op(ov[i], av[i], av[i]);
      wait_done(lat, rdy_hi);
      checks++;
      if (out_result !== ev[i] || lat != LAT) begin
        errors++;
        $display("FAIL corner%0d: got %h lat %0d required %h lat %0d", i, out_result, lat, ev[i], LAT);
      end
      pop();
    end
  endtask

  task automatic test_backpressure();
    int lat; bit rdy_hi;
    logic [W-1:0] exp_r;
    exp_r = ref_result(2'b01, 64'hDEAD_BEEF_1234_5678, 64'h0F0F_F0F0_AAAA_5555);
    start_op(2'b01, 64'hDEAD_BEEF_1234_5678, 64'h0F0F_F0F0_AAAA_5555);
    wait_done(lat, rdy_hi);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== exp_r || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: vld=%0b res=%h required 1 %h", c, out_valid, out_result, exp_r);
      end
      @(posedge clk); #1;
    end
    pop();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    int lat; bit rdy_hi; bit seen;
    logic [W-1:0] exp_r;
    start_op(2'b00, 64'h1234, 64'h5678);
    repeat (7) begin @(posedge clk); #1; end
    flush = 1; in_valid = 1; in_op = 2'b00; in_a = 64'h77; in_b = 64'h99;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_busy: vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
    end
    seen = 0;
    repeat (20) begin if (out_valid || !in_ready) seen = 1; @(posedge clk); #1; end
    checks++;
    if (seen) begin errors++; $display("FAIL flush_nothing_accepted: activity seen 1 required 0"); end
    exp_r = ref_result(2'b10, 64'hCAFE_F00D_0000_0001, 64'h8000_0000_0000_0003);
    start_op(2'b10, 64'hCAFE_F00D_0000_0001, 64'h8000_0000_0000_0003);
    wait_done(lat, rdy_hi);
    checks++;
    if (out_result !== exp_r || lat != LAT) begin
      errors++; $display("FAIL flush_followup: got %h lat %0d required %h lat %0d", out_result, lat, exp_r, LAT);
    end
    pop();
    // flush beats a simultaneous output handshake in DONE
    start_op(2'b00, 64'h3, 64'h5);
    wait_done(lat, rdy_hi);
    flush = 1; out_ready = 1;
    @(posedge clk); #1;
    flush = 0; out_ready = 0;
    seen = 0;
    repeat (20) begin if (out_valid) seen = 1; @(posedge clk); #1; end
    checks++;
    if (seen || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_done: vld seen %0b rdy %0b required 0 1", seen, in_ready);
    end
  endtask

  task automatic test_async_reset();
    int lat; bit rdy_hi; bit seen;
    start_op(2'b01, 64'hFFFF_0000_FFFF_0000, 64'h1357_9BDF_2468_ACE0);
    repeat (5) begin @(posedge clk); #1; end
    #3 rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== '0) begin
      errors++; $display("FAIL arst_busy: vld=%0b rdy=%0b res=%h required 0 1 0", out_valid, in_ready, out_result);
    end
    @(posedge clk); #1; rst_n = 1;
    seen = 0;
    repeat (25) begin if (out_valid) seen = 1; @(posedge clk); #1; end
    checks++;
    if (seen) begin errors++; $display("FAIL arst_no_result: out_valid seen 1 required 0"); end
    start_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(lat, rdy_hi);
    #3 rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== '0) begin
      errors++; $display("FAIL arst_done: vld=%0b rdy=%0b res=%h required 0 1 0", out_valid, in_ready, out_result);
    end
    @(posedge clk); #1; rst_n = 1;
  endtask

  task automatic test_random();
    int lat; bit rdy_hi;
    logic [1:0]   op;
    logic [W-1:0] a, b, exp_r;
    for (int n = 0; n < 2000; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      if (n % 17 == 0) a = 64'h8000_0000_0000_0000 >> $urandom_range(0, 63);
      if (n % 23 == 0) b = '1;
      exp_r = ref_result(op, a, b);
      start_op(op, a, b);
      wait_done(lat, rdy_hi);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      checks++;
      if (out_result !== exp_r || lat != LAT || rdy_hi || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d op%0d: got %h lat %0d required %h lat %0d", n, op, out_result, lat, exp_r, LAT);
      end
      pop();
    end
  endtask

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; in_op = 0; in_a = 0; in_b = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
